// File: rtl/motor_status_monitor.sv
// motor_status_monitor: synchronise and debounce motor power-fail / end-switch lines,
// latch sticky faults and switch events, and raise a summary interrupt once armed.
module motor_status_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit RESET_VAL       = 1'b0
) (
    input  logic clk_ix,
    input  logic rstn_ix,
    input  logic raw_i,
    output logic deb_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q, deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = (s2_q != deb_q && cnt_q == LAST) ? s2_q : deb_q;
        cnt_d = (s2_q == deb_q || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_ix or negedge rstn_ix) begin
        if (!rstn_ix) begin
            s1_q  <= RESET_VAL;
            s2_q  <= RESET_VAL;
            deb_q <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module motor_status_monitor #(
    parameter int NUM_MOTORS       = 16,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter bit PFAIL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_ix,
    input  logic                  rstn_ix,
    input  logic [1:NUM_MOTORS]   pl_pfail_ix,
    input  logic [1:NUM_MOTORS]   pl_sw_outa_ix,
    input  logic [1:NUM_MOTORS]   pl_sw_outb_ix,
    output logic [1:NUM_MOTORS]   sw_a_ox,
    output logic [1:NUM_MOTORS]   sw_b_ox,
    output logic [1:NUM_MOTORS]   pfail_ox,
    output logic [1:NUM_MOTORS]   fault_ox,
    input  logic [1:NUM_MOTORS]   fault_clear_ix,
    output logic [1:NUM_MOTORS]   event_pending_ox,
    input  logic [1:NUM_MOTORS]   event_ack_ix,
    output logic                  irq_ox,
    output logic                  ready_ox
);
    localparam int AW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [AW-1:0] ARM_LAST = AW'(DEBOUNCE_CYCLES + 2);

    logic [AW-1:0]       arm_q, arm_d;
    logic                ready_q, ready_d, irq_q, irq_d;
    logic [1:NUM_MOTORS] pf_deb, chg;
    logic [1:NUM_MOTORS] prev_a_q, prev_b_q, fault_q, fault_d, event_q, event_d;

    for (genvar i = 1; i <= NUM_MOTORS; i++) begin : g_ch
        motor_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_a (
            .clk_ix(clk_ix), .rstn_ix(rstn_ix), .raw_i(pl_sw_outa_ix[i]), .deb_o(sw_a_ox[i]));
        motor_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_b (
            .clk_ix(clk_ix), .rstn_ix(rstn_ix), .raw_i(pl_sw_outb_ix[i]), .deb_o(sw_b_ox[i]));
        motor_status_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(PFAIL_ACTIVE_LOW)) u_p (
            .clk_ix(clk_ix), .rstn_ix(rstn_ix), .raw_i(pl_pfail_ix[i]), .deb_o(pf_deb[i]));
    end

    assign pfail_ox = pf_deb ^ {NUM_MOTORS{PFAIL_ACTIVE_LOW}};
    // a debounced change is visible for exactly the one cycle before prev catches up
    assign chg      = (sw_a_ox ^ prev_a_q) | (sw_b_ox ^ prev_b_q);

    always_comb begin
        arm_d   = (ready_q || arm_q == ARM_LAST) ? arm_q : arm_q + AW'(1);
        ready_d = ready_q | (arm_q == ARM_LAST);
        fault_d = ({NUM_MOTORS{ready_q}} & pfail_ox) | (fault_q & ~(fault_clear_ix & ~pfail_ox));
        event_d = ({NUM_MOTORS{ready_q}} & chg) | (event_q & ~event_ack_ix);
        irq_d   = |{fault_q, event_q};
    end

    always_ff @(posedge clk_ix or negedge rstn_ix) begin
        if (!rstn_ix) begin
            arm_q    <= '0;
            ready_q  <= 1'b0;
            irq_q    <= 1'b0;
            prev_a_q <= '0;
            prev_b_q <= '0;
            fault_q  <= '0;
            event_q  <= '0;
        end else begin
            arm_q    <= arm_d;
            ready_q  <= ready_d;
            irq_q    <= irq_d;
            prev_a_q <= sw_a_ox;
            prev_b_q <= sw_b_ox;
            fault_q  <= fault_d;
            event_q  <= event_d;
        end
    end

    assign fault_ox         = fault_q;
    assign event_pending_ox = event_q;
    assign irq_ox           = irq_q;
    assign ready_ox         = ready_q;
endmodule

// File: tb/tb_motor_status_monitor.sv
// tb_motor_status_monitor: vector table, directed reset/arming sequences and a random run
// checked against a window-based reference model of the monitor.
module tb_motor_status_monitor;
    localparam int N = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [1:N] a, b, pf, ack, clr;
    logic [1:N] sw_a, sw_b, pfail, fault, evp;
    logic irq, ready;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    motor_status_monitor #(.NUM_MOTORS(N), .DEBOUNCE_CYCLES(D), .PFAIL_ACTIVE_LOW(1'b1)) dut (
        .clk_ix(clk), .rstn_ix(rstn), .pl_pfail_ix(pf), .pl_sw_outa_ix(a), .pl_sw_outb_ix(b),
        .sw_a_ox(sw_a), .sw_b_ox(sw_b), .pfail_ox(pfail), .fault_ox(fault),
        .fault_clear_ix(clr), .event_pending_ox(evp), .event_ack_ix(ack),
        .irq_ox(irq), .ready_ox(ready));

    // model: a line's debounced level flips when its last D synchronised samples all disagree
    logic [D:0] hist [3*N];
    logic       mdeb [3*N];
    logic       mchg [3*N];
    logic [1:N] mfault, mev;
    logic       mirq;
    int         medges;

    function automatic logic pin(int ln);
        return ln < N ? a[ln+1] : ln < 2*N ? b[ln-N+1] : pf[ln-2*N+1];
    endfunction

    function automatic logic [1:N] mvec(int base);
        logic [1:N] v;
        for (int ch = 1; ch <= N; ch++) v[ch] = mdeb[base+ch-1];
        return v;
    endfunction

    task automatic model_reset();
        for (int ln = 0; ln < 3*N; ln++) begin
            mdeb[ln] = ln >= 2*N;
            hist[ln] = {(D+1){ln >= 2*N}};
            mchg[ln] = 1'b0;
        end
        mfault = '0;
        mev    = '0;
        mirq   = 1'b0;
        medges = 0;
    endtask

    task automatic model_step();
        logic       rdy, nirq;
        logic [1:N] mpf;
        rdy  = medges >= D + 3;
        mpf  = ~mvec(2*N);
        nirq = |{mfault, mev};
        for (int ch = 1; ch <= N; ch++) begin
            if (rdy && mpf[ch]) mfault[ch] = 1'b1;
            else if (clr[ch] && !mpf[ch]) mfault[ch] = 1'b0;
            if (rdy && (mchg[ch-1] || mchg[N+ch-1])) mev[ch] = 1'b1;
            else if (ack[ch]) mev[ch] = 1'b0;
        end
        for (int ln = 0; ln < 3*N; ln++) begin
            mchg[ln] = hist[ln][D:1] == {D{~mdeb[ln]}};
            if (mchg[ln]) mdeb[ln] = ~mdeb[ln];
            hist[ln] = {hist[ln][D-1:0], pin(ln)};
        end
        mirq = nirq;
        medges++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string t, input logic [1:N] esa, input logic [1:N] esb,
                           input logic [1:N] epf, input logic [1:N] eft, input logic [1:N] eev,
                           input logic eirq, input logic erdy);
        chk({t, " sw_a"}, sw_a, esa);
        chk({t, " sw_b"}, sw_b, esb);
        chk({t, " pfail"}, pfail, epf);
        chk({t, " fault"}, fault, eft);
        chk({t, " event"}, evp, eev);
        chk({t, " irq"}, N'(irq), N'(eirq));
        chk({t, " ready"}, N'(ready), N'(erdy));
    endtask

    typedef struct {
        logic [1:N] a, b, pf, ack, clr;
        int         cyc;
        logic [1:N] swa, swb, pfo, flt, ev;
        logic       irq;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t row(logic [1:N] ia, logic [1:N] ib, logic [1:N] ipf, logic [1:N] iack,
                                 logic [1:N] iclr, int c, logic [1:N] esa, logic [1:N] esb,
                                 logic [1:N] epf, logic [1:N] eft, logic [1:N] eev, logic eirq);
        vec_t r;
        r.a = ia; r.b = ib; r.pf = ipf; r.ack = iack; r.clr = iclr; r.cyc = c;
        r.swa = esa; r.swb = esb; r.pfo = epf; r.flt = eft; r.ev = eev; r.irq = eirq;
        return r;
    endfunction

    function automatic logic [1:N] oh(int i);
        logic [1:N] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [1:N] z, one, o1, o3, o5, o16, o35;
        z = '0; one = '1; o1 = oh(1); o3 = oh(3); o5 = oh(5); o16 = oh(16); o35 = o3 | o5;
        a = z; b = z; pf = one; ack = z; clr = z;
        model_reset();
        #12;
        chk_all("in_reset", z, z, z, z, z, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (D + 2) tick();
        chk_all("arming", z, z, z, z, z, 1'b0, 1'b0);
        tick();
        chk_all("armed", z, z, z, z, z, 1'b0, 1'b1);

        tbl.push_back(row(o3, z, one, z, z, 5, z, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, z, one, z, z, 1, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, z, one, z, z, 1, o3, z, z, z, o3, 1'b0));
        tbl.push_back(row(o3, z, one, z, z, 1, o3, z, z, z, o3, 1'b1));
        tbl.push_back(row(o3, z, one, o3, z, 1, o3, z, z, z, z, 1'b1));
        tbl.push_back(row(o3, z, one, z, z, 1, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, o16, one, z, z, 3, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, z, one, z, z, 8, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, z, ~o1, z, z, 5, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o3, z, ~o1, z, z, 1, o3, z, o1, z, z, 1'b0));
        tbl.push_back(row(o3, z, ~o1, z, z, 1, o3, z, o1, o1, z, 1'b0));
        tbl.push_back(row(o3, z, ~o1, z, o1, 2, o3, z, o1, o1, z, 1'b1));
        tbl.push_back(row(o3, z, one, z, z, 6, o3, z, z, o1, z, 1'b1));
        tbl.push_back(row(o3, z, one, z, o1, 1, o3, z, z, z, z, 1'b1));
        tbl.push_back(row(o3, z, one, z, z, 1, o3, z, z, z, z, 1'b0));
        tbl.push_back(row(o35, z, one, z, z, 6, o35, z, z, z, z, 1'b0));
        tbl.push_back(row(o35, z, one, o5, z, 1, o35, z, z, z, o5, 1'b0));
        tbl.push_back(row(o35, z, one, z, z, 1, o35, z, z, z, o5, 1'b1));
        tbl.push_back(row(o35, z, one, o5, z, 1, o35, z, z, z, z, 1'b1));
        tbl.push_back(row(o35, z, one, z, z, 1, o35, z, z, z, z, 1'b0));

        foreach (tbl[k]) begin
            a = tbl[k].a; b = tbl[k].b; pf = tbl[k].pf; ack = tbl[k].ack; clr = tbl[k].clr;
            tick();
            ack = z; clr = z;
            for (int c = 1; c < tbl[k].cyc; c++) tick();
            chk_all($sformatf("row%0d", k), tbl[k].swa, tbl[k].swb, tbl[k].pfo, tbl[k].flt,
                    tbl[k].ev, tbl[k].irq, 1'b1);
        end

        rstn = 1'b0;
        model_reset();
        #1;
        chk_all("async_reset", z, z, z, z, z, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) tick();
        a = o35 | oh(9);
        repeat (3) tick();
        chk("settle_while_arming sw_a", sw_a, o35);
        chk("settle_while_arming ready", N'(ready), N'(1'b0));
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk_all("mid_arm_reset", z, z, z, z, z, 1'b0, 1'b0);
        a = o35;
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) tick();
        chk_all("rearm_stable", o35, z, z, z, z, 1'b0, 1'b1);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int ch = 1; ch <= N; ch++) begin
                if ($urandom_range(11) == 0) a[ch] = ~a[ch];
                if ($urandom_range(11) == 0) b[ch] = ~b[ch];
                if ($urandom_range(11) == 0) pf[ch] = ~pf[ch];
                ack[ch] = $urandom_range(7) == 0;
                clr[ch] = $urandom_range(7) == 0;
            end
            tick();
            chk_all($sformatf("rand%0d", cyc), mvec(0), mvec(N), ~mvec(2*N), mfault, mev, mirq,
                    medges >= D + 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
